// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready request port, configurable wait states,
// byte-lane RAM writes, a decoded MMIO window and alignment/range error reporting.
module dmem_ctrl #(
    parameter int          ADDR_WIDTH  = 6,
    parameter int          DATA_WIDTH  = 32,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [31:0]               req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_be,
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic                      mmio_we,
    output logic [31:0]               mmio_addr,
    output logic [DATA_WIDTH-1:0]     mmio_wdata,
    input  logic [DATA_WIDTH-1:0]     mmio_rdata
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Wait counter starts one below the wait count so WAIT lasts exactly WAIT_STATES cycles.
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              cnt;

    // Request fields captured at accept.
    logic                    lat_write;
    logic                    lat_mmio;
    logic [ADDR_WIDTH-1:0]   lat_idx;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic [NB-1:0]           lat_be;

    // Response and MMIO output registers.
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;
    logic [31:0]             mmio_addr_q;
    logic [DATA_WIDTH-1:0]   mmio_wdata_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    accept;
    logic                    req_misaligned;
    logic                    req_is_mmio;
    logic                    req_unmapped;
    logic                    req_bad;

    // Zero every byte lane whose enable bit is clear.
    function automatic logic [DATA_WIDTH-1:0] apply_be(input logic [DATA_WIDTH-1:0] d,
                                                       input logic [NB-1:0] be);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    // Address decode of the incoming request.
    always_comb begin
        req_misaligned = (req_addr[1:0] != 2'b00);
        req_is_mmio    = (req_addr >= MMIO_BASE);
        req_unmapped   = !req_is_mmio && ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0);
        req_bad        = req_misaligned || req_unmapped;
        accept         = (state == S_IDLE) && req_valid;
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_err    = 1'b0;
        rsp_rdata  = '0;
        mmio_we    = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_bad)               state_next = S_RESP;
                    else if (WAIT_STATES > 0)  state_next = S_WAIT;
                    else                       state_next = S_ACCESS;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) state_next = S_ACCESS;
            end
            S_ACCESS: begin
                mmio_we    = lat_write && lat_mmio;
                state_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid  = 1'b1;
                rsp_err    = err_q;
                rsp_rdata  = rdata_q;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register, wait counter and response/MMIO output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= 4'd0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            mmio_addr_q  <= '0;
            mmio_wdata_q <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt     <= CNT_INIT;
                rdata_q <= '0;
                err_q   <= req_bad;
                if (!req_bad && req_is_mmio) begin
                    mmio_addr_q  <= req_addr;
                    mmio_wdata_q <= req_write ? apply_be(req_wdata, req_be) : '0;
                end
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state == S_ACCESS && !lat_write) begin
                rdata_q <= lat_mmio ? mmio_rdata : mem[lat_idx];
            end
        end
    end

    // Request capture; pure datapath, only meaningful after an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_write <= req_write;
            lat_mmio  <= req_is_mmio;
            lat_idx   <= req_addr[ADDR_WIDTH+1:2];
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
        end
    end

    // RAM store at the ACCESS closing edge; a coincident reset suppresses the commit.
    always_ff @(posedge clk) begin
        if (state == S_ACCESS && lat_write && !lat_mmio && !reset) begin
            for (int i = 0; i < NB; i++) begin
                if (lat_be[i]) mem[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
            end
        end
    end

    assign mmio_addr  = mmio_addr_q;
    assign mmio_wdata = mmio_wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: table of directed transactions, hand-written reset
// sequences, and a wait-state latency sweep across three extra instances.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mmio_we;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic [31:0] mmio_rdata;

    int tests = 0;
    int fails = 0;

    dmem_ctrl #(
        .ADDR_WIDTH(6), .DATA_WIDTH(32), .WAIT_STATES(1), .MMIO_BASE(32'h8000_0000)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mmio_we(mmio_we), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
        .mmio_rdata(mmio_rdata)
    );

    // Wait-state sweep instances share clock, reset and a held-high request.
    localparam int SW_WS [3] = '{0, 3, 15};
    logic        sw_valid;
    logic        sw_ready    [3];
    logic        sw_rsp_valid[3];
    logic        sw_err      [3];
    logic        sw_we       [3];
    logic [31:0] sw_rdata    [3];
    logic [31:0] sw_maddr    [3];
    logic [31:0] sw_mwdata   [3];

    for (genvar g = 0; g < 3; g++) begin : g_sw
        dmem_ctrl #(
            .ADDR_WIDTH(6), .DATA_WIDTH(32), .WAIT_STATES(SW_WS[g]), .MMIO_BASE(32'h8000_0000)
        ) u_sw (
            .clk(clk), .reset(reset),
            .req_valid(sw_valid), .req_ready(sw_ready[g]), .req_write(1'b1),
            .req_addr(32'h0000_0000), .req_wdata(32'h0000_0000), .req_be(4'hF),
            .rsp_valid(sw_rsp_valid[g]), .rsp_rdata(sw_rdata[g]), .rsp_err(sw_err[g]),
            .mmio_we(sw_we[g]), .mmio_addr(sw_maddr[g]), .mmio_wdata(sw_mwdata[g]),
            .mmio_rdata(32'h0000_0000)
        );
    end

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] mrd;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_lat;
        int          exp_we;
        logic [31:0] exp_maddr;
        logic [31:0] exp_mwd;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One complete transaction; returns what was observed up to and including the response.
    task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input logic [31:0] mrd,
                          output logic [31:0] rd, output logic err, output int lat,
                          output int we_cnt, output logic [31:0] maddr,
                          output logic [31:0] mwd, output bit ready_ok);
        @(negedge clk);
        req_write  = wr;
        req_addr   = a;
        req_wdata  = wd;
        req_be     = be;
        mmio_rdata = mrd;
        req_valid  = 1'b1;
        ready_ok   = (req_ready === 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; we_cnt = 0; rd = 'x; err = 1'bx; maddr = '0; mwd = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (req_ready !== 1'b0) ready_ok = 1'b0;
            if (mmio_we === 1'b1) begin
                we_cnt++;
                maddr = mmio_addr;
                mwd   = mmio_wdata;
            end
            if (rsp_valid === 1'b1) begin
                lat = i;
                rd  = rsp_rdata;
                err = rsp_err;
                break;
            end
        end
    endtask

    // Count responses over a window; used after an abandoned request.
    task automatic count_rsp(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) n++;
        end
    endtask

    logic [31:0] rd, maddr, mwd;
    logic        err;
    int          lat, we_cnt, nrsp;
    bit          ready_ok;
    int          acc_c [3];
    int          n_rsp [3];
    bit          inflight [3];
    bit          ready_bad [3];

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_be = '0; mmio_rdata = '0; sw_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset req_ready",  32'(req_ready),  32'd1);
        check("reset rsp_valid",  32'(rsp_valid),  32'd0);
        check("reset rsp_err",    32'(rsp_err),    32'd0);
        check("reset rsp_rdata",  rsp_rdata,       32'd0);
        check("reset mmio_we",    32'(mmio_we),    32'd0);
        check("reset mmio_addr",  mmio_addr,       32'd0);
        check("reset mmio_wdata", mmio_wdata,      32'd0);
        reset = 1'b0;

        //            wr    addr            wdata          be     mrd           exp_rd        err  lat we maddr          mwd
        vecs.push_back('{1'b1, 32'h0000_0000, 32'h0000_0000, 4'hF, 32'h0,      32'h0,        1'b0, 3, 0, 32'h0,          32'h0});
        vecs.push_back('{1'b1, 32'h0000_0030, 32'h0000_0000, 4'hF, 32'h0,      32'h0,        1'b0, 3, 0, 32'h0,          32'h0});
        vecs.push_back('{1'b1, 32'h0000_0034, 32'h0000_0000, 4'hF, 32'h0,      32'h0,        1'b0, 3, 0, 32'h0,          32'h0});
        vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,      32'h0,        1'b0, 3, 0, 32'h0,          32'h0});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'h0,      32'hDEAD_BEEF,1'b0, 3, 0, 32'h0,          32'h0});
        vecs.push_back('{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0,      32'h0,        1'b0, 3, 0, 32'h0,          32'h0});
        vecs.push_back('{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0,      32'h0,        1'b0, 3, 0, 32'h0,          32'h0});
        vecs.push_back('{1'b0, 32'h0000_0020, 32'h0000_0000, 4'h0, 32'h0,      32'h11BB_33DD,1'b0, 3, 0, 32'h0,          32'h0});
        vecs.push_back('{1'b0, 32'h0000_0022, 32'h0000_0000, 4'h0, 32'h0,      32'h0,        1'b1, 1, 0, 32'h0,          32'h0});
        vecs.push_back('{1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 4'hF, 32'h0,      32'h0,        1'b1, 1, 0, 32'h0,          32'h0});
        vecs.push_back('{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 32'h0,      32'h0,        1'b0, 3, 0, 32'h0,          32'h0});
        vecs.push_back('{1'b1, 32'h0000_0021, 32'hFFFF_FFFF, 4'hF, 32'h0,      32'h0,        1'b1, 1, 0, 32'h0,          32'h0});
        vecs.push_back('{1'b0, 32'h0000_0020, 32'h0000_0000, 4'h0, 32'h0,      32'h11BB_33DD,1'b0, 3, 0, 32'h0,          32'h0});
        vecs.push_back('{1'b1, 32'h8000_0004, 32'h0000_005A, 4'hF, 32'h0,      32'h0,        1'b0, 3, 1, 32'h8000_0004,  32'h0000_005A});
        vecs.push_back('{1'b0, 32'h8000_0000, 32'h0000_0000, 4'h0, 32'h1234,   32'h0000_1234,1'b0, 3, 0, 32'h0,          32'h0});
        vecs.push_back('{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0,      32'h0,        1'b0, 3, 0, 32'h0,          32'h0});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'h0,      32'hDEAD_BEEF,1'b0, 3, 0, 32'h0,          32'h0});
        vecs.push_back('{1'b1, 32'h8000_0008, 32'h1122_3344, 4'h2, 32'h0,      32'h0,        1'b0, 3, 1, 32'h8000_0008,  32'h0000_3300});
        vecs.push_back('{1'b1, 32'h0000_00FC, 32'h0BAD_F00D, 4'hF, 32'h0,      32'h0,        1'b0, 3, 0, 32'h0,          32'h0});
        vecs.push_back('{1'b0, 32'h0000_00FC, 32'h0000_0000, 4'h0, 32'h0,      32'h0BAD_F00D,1'b0, 3, 0, 32'h0,          32'h0});
        vecs.push_back('{1'b0, 32'h0000_0100, 32'h0000_0000, 4'h0, 32'h0,      32'h0,        1'b1, 1, 0, 32'h0,          32'h0});
        vecs.push_back('{1'b0, 32'h7FFF_FFFC, 32'h0000_0000, 4'h0, 32'h0,      32'h0,        1'b1, 1, 0, 32'h0,          32'h0});

        foreach (vecs[k]) begin
            do_req(vecs[k].wr, vecs[k].addr, vecs[k].wdata, vecs[k].be, vecs[k].mrd,
                   rd, err, lat, we_cnt, maddr, mwd, ready_ok);
            check($sformatf("v%0d latency", k), 32'(lat), 32'(vecs[k].exp_lat));
            check($sformatf("v%0d rdata", k), rd, vecs[k].exp_rd);
            check($sformatf("v%0d err", k), 32'(err), 32'(vecs[k].exp_err));
            check($sformatf("v%0d mmio_we pulses", k), 32'(we_cnt), 32'(vecs[k].exp_we));
            check($sformatf("v%0d ready handshake", k), 32'(ready_ok), 32'd1);
            if (vecs[k].exp_we != 0) begin
                check($sformatf("v%0d mmio_addr", k), maddr, vecs[k].exp_maddr);
                check($sformatf("v%0d mmio_wdata", k), mwd, vecs[k].exp_mwd);
            end
        end

        // Reset during WAIT of a RAM store: abandoned, no response, no write.
        @(negedge clk);
        req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h1234_5678; req_be = 4'hF;
        req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        count_rsp(6, nrsp);
        check("rst-wait no response", 32'(nrsp), 32'd0);
        check("rst-wait ready after", 32'(req_ready), 32'd1);
        do_req(1'b0, 32'h30, 32'h0, 4'h0, 32'h0, rd, err, lat, we_cnt, maddr, mwd, ready_ok);
        check("rst-wait 0x30 data", rd, 32'h0);
        check("rst-wait next latency", 32'(lat), 32'd3);

        // Reset coinciding with the ACCESS closing edge of a RAM store: not committed.
        @(negedge clk);
        req_write = 1'b1; req_addr = 32'h34; req_wdata = 32'hCAFE_F00D; req_be = 4'hF;
        req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        count_rsp(6, nrsp);
        check("rst-access no response", 32'(nrsp), 32'd0);
        do_req(1'b0, 32'h34, 32'h0, 4'h0, 32'h0, rd, err, lat, we_cnt, maddr, mwd, ready_ok);
        check("rst-access 0x34 data", rd, 32'h0);

        // Reset during ACCESS of an MMIO store: strobe and latched outputs cleared.
        @(negedge clk);
        req_write = 1'b1; req_addr = 32'h8000_000C; req_wdata = 32'h77; req_be = 4'hF;
        req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst-mmio strobe before", 32'(mmio_we), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("rst-mmio strobe after", 32'(mmio_we), 32'd0);
        check("rst-mmio addr after", mmio_addr, 32'h0);
        check("rst-mmio wdata after", mmio_wdata, 32'h0);
        count_rsp(6, nrsp);
        check("rst-mmio no response", 32'(nrsp), 32'd0);

        // Reset and req_valid together: request is not accepted.
        @(negedge clk);
        req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h5555_5555; req_be = 4'hF;
        req_valid = 1'b1; reset = 1'b1;
        @(posedge clk); #1 begin req_valid = 1'b0; reset = 1'b0; end
        count_rsp(6, nrsp);
        check("rst+valid no response", 32'(nrsp), 32'd0);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 32'h0, rd, err, lat, we_cnt, maddr, mwd, ready_ok);
        check("rst+valid 0x10 data", rd, 32'hDEAD_BEEF);

        // Wait-state sweep with req_valid held high.
        for (int g = 0; g < 3; g++) begin
            acc_c[g] = 0; n_rsp[g] = 0; inflight[g] = 1'b0; ready_bad[g] = 1'b0;
        end
        @(negedge clk);
        sw_valid = 1'b1;
        for (int c = 0; c < 80; c++) begin
            for (int g = 0; g < 3; g++) begin
                if (inflight[g] && sw_ready[g] !== 1'b0) ready_bad[g] = 1'b1;
                if (inflight[g] && sw_rsp_valid[g] === 1'b1) begin
                    check($sformatf("ws%0d latency", SW_WS[g]), 32'(c - acc_c[g]),
                          32'(SW_WS[g] + 2));
                    check($sformatf("ws%0d err", SW_WS[g]), 32'(sw_err[g]), 32'd0);
                    check($sformatf("ws%0d ready low in flight", SW_WS[g]),
                          32'(ready_bad[g]), 32'd0);
                    inflight[g]  = 1'b0;
                    ready_bad[g] = 1'b0;
                    n_rsp[g]++;
                end else if (!inflight[g] && sw_ready[g] === 1'b1) begin
                    acc_c[g]    = c;
                    inflight[g] = 1'b1;
                end
            end
            @(negedge clk);
        end
        sw_valid = 1'b0;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("ws%0d enough responses", SW_WS[g]), 32'(n_rsp[g] >= 2), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
